product_accumulator: RTL
========================

Name: product_accumulator

Overview:
Sequential stage directly downstream of the 4x4 array multiplier. Consumes its 8-bit products over a valid/ready handshake and sums groups of COUNT products. A group may also be closed early with in_last. Emits each group sum with a valid/ready handshake, forming the accumulate half of a multiply-accumulate (dot-product) datapath.

Parameters:
IN_W, 8, product width; matches the multiplier output p[7:0]
COUNT, 4, products per group (COUNT >= 1)
ACC_W, IN_W + $clog2(COUNT), accumulator and result width; derived localparam, never overflows for unsigned inputs
CNT_W, $clog2(COUNT+1), width of the beat counter and of group_len

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous, active-low reset
p_in  input  IN_W  unsigned product from the multiplier
in_valid  input  1  p_in valid
in_last  input  1  closes the current group after this beat; qualified by in_valid
in_ready  output  1  stage can accept p_in this cycle
clear  input  1  synchronous abort of the current group
acc_out  output  ACC_W  group sum
group_len  output  CNT_W  number of products summed into acc_out
out_valid  output  1  acc_out/group_len valid
out_ready  input  1  downstream accepts the result

Behaviour:
- States: ACCUM (collecting) and HOLD (result presented). All outputs are registered except in_ready.
- in_ready = (state == ACCUM) && !clear. This is combinational and has no dependence on out_ready.
- Reset (rst_n = 0 at a clk edge):
  - State goes to ACCUM; acc and cnt are cleared.
  - acc_out = 0, group_len = 0, out_valid = 0; in_ready reads 1.
  - Reset has priority over everything, including mid-group and mid-HOLD. A pending result is discarded.
- Beat accept (in_valid && in_ready):
  - p_in is zero-extended to ACC_W. Then acc <= acc + p_in and cnt <= cnt + 1.
  - Zero-valued products count as beats.
- Group close: on an accepted beat where cnt + 1 == COUNT or in_last == 1:
  - acc_out <= acc + p_in; group_len <= cnt + 1.
  - acc <= 0; cnt <= 0; out_valid <= 1; state goes to HOLD.
  - Latency: the result is visible on the cycle after the closing beat's edge.
- HOLD:
  - in_ready = 0. acc_out, group_len and out_valid stay stable until out_ready = 1.
  - On out_ready: out_valid <= 0 and state returns to ACCUM. One bubble cycle is mandatory; no input is accepted in the draining cycle.
- out_ready in ACCUM is ignored.
- clear = 1, rst_n = 1:
  - acc and cnt are cleared; state goes to ACCUM; out_valid <= 0; acc_out and group_len <= 0.
  - A beat presented the same cycle is not accepted, because in_ready is 0.
  - clear in HOLD discards the result even when out_ready = 1.
- in_last with in_valid = 0 has no effect. in_last on the COUNT-th beat closes a single group; no empty group is ever produced.
- COUNT = 1: every accepted beat closes a group; acc_out = p_in and group_len = 1.

Decomposition:
- Package mult_pkg holds:
  - IN_W default (8) and COUNT default (4)
  - ACC_W/CNT_W derivation function (clog2)
  - state enum {ACCUM, HOLD}
- Single module, no sub-module. The accumulator, counter and FSM are small enough to stay flat. The multiplier is instantiated only in the integration bench, not inside this block.

Test Plan:
- Reset, then four beats with back-to-back in_valid: p_in = 110, 225, 140, 72 (11*10, 15*15, 10*14, 9*8) -> one cycle after the 4th beat: out_valid = 1, acc_out = 547, group_len = 4, in_ready = 0.
- Four beats of 225 (15*15) -> acc_out = 900, group_len = 4. This is the maximum sum; no wrap in 10 bits.
- Early close: beat 12 (1*12), then 28 (2*14) with in_last = 1 -> acc_out = 40, group_len = 2. The next group starts from 0.
- Backpressure: group 547 complete, out_ready held 0 for 3 cycles with in_valid = 1 and p_in = 0x55 -> acc_out stays 547, in_ready stays 0, no beat counted. out_ready = 1 -> out_valid falls next edge, and in_ready = 1 that cycle.
- Clear mid-group: accept 110, 225, pulse clear with in_valid = 1 (beat dropped), then 72, 0, 12, 28 -> acc_out = 112, group_len = 4.
- Reset in HOLD: drop rst_n for one cycle while out_valid = 1 and out_ready = 0 -> next edge out_valid = 0, acc_out = 0, group_len = 0, in_ready = 1. The following group of 4 x 1 -> acc_out = 4.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared defaults, width helper and FSM encoding for the MAC datapath.
package mult_pkg;

  localparam int IN_W_DEF  = 8;
  localparam int COUNT_DEF = 4;

  // Ceiling log2. clog2(1) is 0, so COUNT = 1 adds no growth bits.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((1 << r) < v) r++;
    return r;
  endfunction

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_e;

endpackage

// File: rtl/product_accumulator.sv
// Sums groups of COUNT unsigned products (or fewer, closed by in_last) and
// presents each group sum with its length over a valid/ready handshake.
module product_accumulator
  import mult_pkg::*;
#(
  parameter  int IN_W  = IN_W_DEF,
  parameter  int COUNT = COUNT_DEF,
  localparam int ACC_W = IN_W + clog2(COUNT),
  localparam int CNT_W = clog2(COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  p_in,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             clear,
  output logic [ACC_W-1:0] acc_out,
  output logic [CNT_W-1:0] group_len,
  output logic             out_valid,
  input  logic             out_ready
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   sum;
  logic [CNT_W-1:0]   cnt_inc;
  logic               accept;
  logic               close;

  // cnt_q never exceeds COUNT-1, so cnt_q + 1 always fits CNT_W.
  assign sum     = acc_q + ACC_W'(p_in);
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign accept  = in_valid && in_ready;
  assign close   = (cnt_inc == CNT_W'(COUNT)) || in_last;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ACCUM;
    else        state_q <= state_d;
  end

  // FSM next state: clear always wins and returns to collecting
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (accept && close) state_d = HOLD;
        HOLD:    if (out_ready)       state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // FSM output: only in_ready is combinational, independent of out_ready
  always_comb begin
    in_ready = (state_q == ACCUM) && !clear;
  end

  // Accumulator, beat counter and registered result
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      acc_out   <= '0;
      group_len <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      acc_out   <= '0;
      group_len <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      if (close) begin
        acc_out   <= sum;
        group_len <= cnt_inc;
        acc_q     <= '0;
        cnt_q     <= '0;
        out_valid <= 1'b1;
      end else begin
        acc_q <= sum;
        cnt_q <= cnt_inc;
      end
    end else if (state_q == HOLD && out_ready) begin
      // result stays on acc_out/group_len; only the valid drops
      out_valid <= 1'b0;
    end
  end

endmodule
